// File: rtl/mux2_rr_arbiter_if.sv
// Valid/ready bundle for the two requester streams and the shared output stream.
// The master modport is the arbiter's view; the slave modport is the surrounding producers/consumer.
interface mux2_rr_arbiter_if #(
  parameter int DATA_W = 8
);
  logic              s0_valid;
  logic [DATA_W-1:0] s0_data;
  logic              s0_last;
  logic              s0_ready;

  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
  logic              s1_last;
  logic              s1_ready;

  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic              m_ready;

  modport master (
    input  s0_valid, s0_data, s0_last,
    input  s1_valid, s1_data, s1_last,
    input  m_ready,
    output s0_ready, s1_ready,
    output m_valid, m_data, m_last
  );

  modport slave (
    output s0_valid, s0_data, s0_last,
    output s1_valid, s1_data, s1_last,
    output m_ready,
    input  s0_ready, s1_ready,
    input  m_valid, m_data, m_last
  );
endinterface

// File: rtl/mux2_rr_arbiter.sv
// Two-requester round-robin packet arbiter steering a shared 2:1 mux onto one output stream.
// A grant is held until the last beat transfers; priority then passes to the other requester.
module mux2_rr_arbiter #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  mux2_rr_arbiter_if.master    bus,
  output logic                 sel,
  output logic                 busy,
  output logic [CNT_W-1:0]     pkt_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t            state;
  logic              prio;
  logic [DATA_W-1:0] mux_data;

  // On a tie in IDLE, prio picks the winner; sel and busy are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      prio    <= 1'b0;
      sel     <= 1'b0;
      busy    <= 1'b0;
      pkt_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.s0_valid && (!bus.s1_valid || !prio)) begin
            state <= GRANT0;
            sel   <= 1'b0;
            busy  <= 1'b1;
          end else if (bus.s1_valid) begin
            state <= GRANT1;
            sel   <= 1'b1;
            busy  <= 1'b1;
          end
        end
        GRANT0: begin
          if (bus.s0_valid && bus.m_ready && bus.s0_last) begin
            state   <= IDLE;
            prio    <= 1'b1;
            busy    <= 1'b0;
            pkt_cnt <= pkt_cnt + CNT_W'(1);
          end
        end
        GRANT1: begin
          if (bus.s1_valid && bus.m_ready && bus.s1_last) begin
            state   <= IDLE;
            prio    <= 1'b0;
            busy    <= 1'b0;
            pkt_cnt <= pkt_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Zero-latency data path: the mux always follows sel, handshakes are gated by the grant.
  always_comb begin
    mux_data     = sel ? bus.s1_data : bus.s0_data;
    bus.m_data   = mux_data;
    bus.m_last   = sel ? bus.s1_last : bus.s0_last;
    bus.m_valid  = 1'b0;
    bus.s0_ready = 1'b0;
    bus.s1_ready = 1'b0;
    case (state)
      GRANT0: begin
        bus.m_valid  = bus.s0_valid;
        bus.s0_ready = bus.m_ready;
      end
      GRANT1: begin
        bus.m_valid  = bus.s1_valid;
        bus.s1_ready = bus.m_ready;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter: reset, single requester, contention, backpressure,
// reset mid-packet and counter wrap, each step checked against hand-computed values.
module tb_mux2_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel;
  logic       busy;
  logic [3:0] pkt_cnt;
  int         checks = 0;
  int         errors = 0;

  mux2_rr_arbiter_if #(.DATA_W(8)) bus ();

  mux2_rr_arbiter #(.DATA_W(8), .CNT_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.master),
    .sel     (sel),
    .busy    (busy),
    .pkt_cnt (pkt_cnt)
  );

  always #5 clk = ~clk;

  // Inputs change just after a rising edge; outputs are sampled on the following falling edge.
  task automatic applyStimulus(input logic r,
                               input logic s0v, input logic [7:0] s0d, input logic s0l,
                               input logic s1v, input logic [7:0] s1d, input logic s1l,
                               input logic mr);
    @(posedge clk);
    #1;
    rst          = r;
    bus.s0_valid = s0v;
    bus.s0_data  = s0d;
    bus.s0_last  = s0l;
    bus.s1_valid = s1v;
    bus.s1_data  = s1d;
    bus.s1_last  = s1l;
    bus.m_ready  = mr;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkIdle(input string tag, input logic s, input int cnt);
    checkOutput({tag, ".m_valid"},  32'(bus.m_valid),  32'd0);
    checkOutput({tag, ".s0_ready"}, 32'(bus.s0_ready), 32'd0);
    checkOutput({tag, ".s1_ready"}, 32'(bus.s1_ready), 32'd0);
    checkOutput({tag, ".busy"},     32'(busy),         32'd0);
    checkOutput({tag, ".sel"},      32'(sel),          32'(s));
    checkOutput({tag, ".pkt_cnt"},  32'(pkt_cnt),      32'(cnt));
  endtask

  task automatic checkGrant(input string tag, input logic s, input logic [7:0] d,
                            input logic l, input logic r0, input logic r1);
    checkOutput({tag, ".m_valid"},  32'(bus.m_valid),  32'd1);
    checkOutput({tag, ".busy"},     32'(busy),         32'd1);
    checkOutput({tag, ".sel"},      32'(sel),          32'(s));
    checkOutput({tag, ".m_data"},   32'(bus.m_data),   32'(d));
    checkOutput({tag, ".m_last"},   32'(bus.m_last),   32'(l));
    checkOutput({tag, ".s0_ready"}, 32'(bus.s0_ready), 32'(r0));
    checkOutput({tag, ".s1_ready"}, 32'(bus.s1_ready), 32'(r1));
  endtask

  initial begin
    rst          = 1'b1;
    bus.s0_valid = 1'b0;
    bus.s0_data  = 8'h00;
    bus.s0_last  = 1'b0;
    bus.s1_valid = 1'b0;
    bus.s1_data  = 8'h00;
    bus.s1_last  = 1'b0;
    bus.m_ready  = 1'b0;
    $display("[TB] start");

    applyStimulus(1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 0, 1);
      checkIdle("reset_idle", 0, 0);
    end

    // Single requester on s1
    applyStimulus(0, 0, 8'h00, 0, 1, 8'hA1, 0, 1);
    checkIdle("single_arb", 0, 0);
    applyStimulus(0, 0, 8'h00, 0, 1, 8'hA1, 0, 1);
    checkGrant("single_b1", 1, 8'hA1, 0, 0, 1);
    applyStimulus(0, 0, 8'h00, 0, 1, 8'hA2, 0, 1);
    checkGrant("single_b2", 1, 8'hA2, 0, 0, 1);
    applyStimulus(0, 0, 8'h00, 0, 1, 8'hA3, 1, 1);
    checkGrant("single_b3", 1, 8'hA3, 1, 0, 1);
    applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 0, 1);
    checkIdle("single_done", 1, 1);

    // Contention: both offer 2-beat packets, prio starts at 0
    applyStimulus(0, 1, 8'h10, 0, 1, 8'h20, 0, 1);
    checkIdle("cont_arb", 1, 1);
    applyStimulus(0, 1, 8'h10, 0, 1, 8'h20, 0, 1);
    checkGrant("cont_p0b0", 0, 8'h10, 0, 1, 0);
    applyStimulus(0, 1, 8'h11, 1, 1, 8'h20, 0, 1);
    checkGrant("cont_p0b1", 0, 8'h11, 1, 1, 0);
    applyStimulus(0, 1, 8'h10, 0, 1, 8'h20, 0, 1);
    checkIdle("cont_bubble1", 0, 2);
    applyStimulus(0, 1, 8'h10, 0, 1, 8'h20, 0, 1);
    checkGrant("cont_p1b0", 1, 8'h20, 0, 0, 1);
    applyStimulus(0, 1, 8'h10, 0, 1, 8'h21, 1, 1);
    checkGrant("cont_p1b1", 1, 8'h21, 1, 0, 1);
    applyStimulus(0, 1, 8'h10, 0, 0, 8'h00, 0, 1);
    checkIdle("cont_bubble2", 1, 3);
    applyStimulus(0, 1, 8'h10, 0, 0, 8'h00, 0, 1);
    checkGrant("cont_p2b0", 0, 8'h10, 0, 1, 0);
    applyStimulus(0, 1, 8'h11, 1, 0, 8'h00, 0, 1);
    checkGrant("cont_p2b1", 0, 8'h11, 1, 1, 0);

    // Backpressure mid-packet on s0 while s1 waits with a single-beat packet
    applyStimulus(0, 1, 8'h30, 0, 0, 8'h00, 0, 1);
    checkIdle("bp_arb", 0, 4);
    applyStimulus(0, 1, 8'h30, 0, 1, 8'h40, 1, 1);
    checkGrant("bp_b0", 0, 8'h30, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 8'h31, 0, 1, 8'h40, 1, 0);
      checkGrant("bp_stall", 0, 8'h31, 0, 0, 0);
    end
    applyStimulus(0, 1, 8'h31, 0, 1, 8'h40, 1, 1);
    checkGrant("bp_resume", 0, 8'h31, 0, 1, 0);
    applyStimulus(0, 1, 8'h32, 1, 1, 8'h40, 1, 1);
    checkGrant("bp_last", 0, 8'h32, 1, 1, 0);
    applyStimulus(0, 0, 8'h00, 0, 1, 8'h40, 1, 1);
    checkIdle("bp_bubble", 0, 5);
    applyStimulus(0, 0, 8'h00, 0, 1, 8'h40, 1, 1);
    checkGrant("bp_s1", 1, 8'h40, 1, 0, 1);

    // Single-beat s0 packet leaves prio at 1, then reset lands mid-packet
    applyStimulus(0, 1, 8'h48, 1, 0, 8'h00, 0, 1);
    checkIdle("single_beat_arb", 1, 6);
    applyStimulus(0, 1, 8'h48, 1, 0, 8'h00, 0, 1);
    checkGrant("single_beat", 0, 8'h48, 1, 1, 0);
    applyStimulus(0, 1, 8'h50, 0, 0, 8'h00, 0, 1);
    checkIdle("rst_arb", 0, 7);
    applyStimulus(0, 1, 8'h50, 0, 0, 8'h00, 0, 1);
    checkGrant("rst_b1", 0, 8'h50, 0, 1, 0);
    applyStimulus(1, 1, 8'h51, 0, 0, 8'h00, 0, 1);
    checkGrant("rst_b2", 0, 8'h51, 0, 1, 0);
    applyStimulus(0, 1, 8'h60, 1, 1, 8'h70, 1, 1);
    checkIdle("post_rst", 0, 0);
    applyStimulus(0, 1, 8'h60, 1, 1, 8'h70, 1, 1);
    checkGrant("prio_after_rst", 0, 8'h60, 1, 1, 0);
    applyStimulus(0, 0, 8'h00, 0, 1, 8'h70, 1, 1);
    checkIdle("post_rst_bubble", 0, 1);
    applyStimulus(0, 0, 8'h00, 0, 1, 8'h70, 1, 1);
    checkGrant("post_rst_s1", 1, 8'h70, 1, 0, 1);
    applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 0, 1);
    checkIdle("post_rst_done", 1, 2);

    // Counter wrap with a 4-bit counter
    applyStimulus(1, 0, 8'h00, 0, 0, 8'h00, 0, 1);
    applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 0, 1);
    checkIdle("wrap_rst", 0, 0);
    for (int k = 1; k <= 17; k++) begin
      applyStimulus(0, 1, 8'(k), 1, 0, 8'h00, 0, 1);
      checkIdle("wrap_idle", 0, (k - 1) % 16);
      applyStimulus(0, 1, 8'(k), 1, 0, 8'h00, 0, 1);
      checkGrant("wrap_beat", 0, 8'(k), 1, 1, 0);
    end
    applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 0, 1);
    checkIdle("wrap_end", 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux2_rr_arbiter.md
# mux2_rr_arbiter

Two-requester round-robin arbiter that shares one 2:1 data multiplexer between two valid/ready packet streams and drives a single output stream. It sequences the mux select line, holds a grant for the full packet (until `last`), and alternates priority between requesters after each packet. It sits directly in front of any single-consumer resource that two producers must share.

## Interface
Parameters:
- `DATA_W`, 8: width of the data path.
- `CNT_W`, 16: width of the completed-packet counter.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  synchronous reset, active-high.
- `s0_valid`  input  1  requester 0 has a beat available.
- `s0_data`  input  DATA_W  requester 0 beat data.
- `s0_last`  input  1  requester 0 beat is the final beat of its packet.
- `s0_ready`  output  1  requester 0 beat accepted this cycle (when `s0_valid` is also high).
- `s1_valid`, `s1_data`, `s1_last`, `s1_ready`: same as above, for requester 1.
- `m_valid`  output  1  output beat valid.
- `m_data`  output  DATA_W  output beat data (mux output).
- `m_last`  output  1  output beat is the final beat of its packet.
- `m_ready`  input  1  consumer accepts the beat.
- `sel`  output  1  current mux select: 0 selects requester 0, 1 selects requester 1.
- `busy`  output  1  high while a grant is held.
- `pkt_cnt`  output  CNT_W  number of completed packets, modulo 2^CNT_W.

## Operation
- FSM states: IDLE, GRANT0, GRANT1 (registered). `prio` is a 1-bit register naming the requester favoured on a tie.
- IDLE:
  - Only `s0_valid` high -> GRANT0. Only `s1_valid` high -> GRANT1.
  - Both high -> GRANT`prio`. Neither high -> stay in IDLE.
- GRANTx:
  - `sel`=x.
  - `m_valid`=`sx_valid`, `m_data`=`sx_data`, `m_last`=`sx_last`.
  - `sx_ready`=`m_ready`; the other requester's ready is 0.
- Transfer occurs when `m_valid & m_ready`. A transfer with `m_last`=1 returns the FSM to IDLE, sets `prio` to the other requester (!x), and increments `pkt_cnt`.
- A transfer without `last`, or no transfer, holds GRANTx. The grant is never revoked mid-packet, regardless of the other requester's valid.
- In IDLE:
  - `m_valid`=0, `s0_ready`=`s1_ready`=0, `busy`=0.
  - `sel` holds its last value.
  - `m_data`/`m_last` follow the mux at `sel`, and are don't-care while `m_valid`=0.
- `busy`=1 in GRANT0/GRANT1.
- `pkt_cnt` wraps from 2^CNT_W−1 to 0 with no flag.
- Protocol rules:
  - Requesters must not drop `valid` or change data/last until accepted.
  - The arbiter does not check this.
  - A single-beat packet (`last`=1 on its first beat) is legal.

## Timing
- Reset (when `rst`=1 at an edge, overriding all else): state=IDLE, `prio`=0, `sel`=0, `pkt_cnt`=0. This gives `m_valid`=0, `s0_ready`=`s1_ready`=0, `busy`=0.
- Reset mid-packet aborts the grant. The partial packet is not counted, and the bench must not expect completion.
- Arbitration latency: a request seen in IDLE at edge N is granted from cycle N+1. The first beat can transfer in cycle N+1 if `m_ready`=1.
- Data path in GRANT is combinational: `m_*` follows `sx_*` and `sx_ready` follows `m_ready` in the same cycle, with zero added latency.
- Last-beat transfer in cycle K:
  - IDLE in cycle K+1, and `pkt_cnt` is updated and visible in cycle K+1.
  - The earliest next grant is cycle K+2, so there is exactly one bubble cycle between packets.
- Throughput for back-to-back contention: L-beat packets take L+1 cycles each, with strict alternation 0,1,0,1…
- A new `valid` arriving on the non-granted side mid-packet has no effect until IDLE.

## Test plan
- Reset then idle: hold `rst`=1 for 2 cycles, then release with all valids 0 for 5 cycles -> `m_valid`=0, both readies 0, `sel`=0, `busy`=0, `pkt_cnt`=0 throughout.
- Single requester: s1 sends 3 beats 0xA1, 0xA2, 0xA3 (last on 0xA3), `m_ready`=1, s0 idle -> `sel`=1 from the cycle after `s1_valid` rises; `m_data` is A1, A2, A3 on consecutive cycles; `pkt_cnt`=1; IDLE the next cycle.
- Contention alternation: both requesters continuously offer 2-beat packets (s0 0x10, 0x11; s1 0x20, 0x21) -> output order 10, 11, bubble, 20, 21, bubble, 10, 11…; `pkt_cnt`=3 after three packets.
- Backpressure: mid-packet on s0, `m_ready`=0 for 4 cycles while `s1_valid`=1 -> `sel` stays 0, `s0_ready`=0, `m_data` holds the stalled beat, `s1_ready`=0; the packet resumes when `m_ready`=1.
- Reset mid-operation: assert `rst` for 1 cycle after beat 1 of a 3-beat s0 packet -> next cycle IDLE, `prio`=0, `pkt_cnt`=0, `busy`=0.
- Counter wrap: with CNT_W=4, send 17 single-beat packets -> `pkt_cnt` reads 15 then 0 then 1.
